// File: rtl/mc_pkg.sv
// Shared command codes for multi_counter and the register-file decoder.
// Illegal command codes collapse onto the hold behaviour through mc_decode.
package mc_pkg;

  localparam logic [7:0] MC_STATE_RESET = 8'd0;
  localparam logic [7:0] MC_STATE_RUN   = 8'd1;
  localparam logic [7:0] MC_STATE_HALT  = 8'd2;

  typedef enum logic [1:0] {
    MC_CMD_RESET = 2'd0,
    MC_CMD_RUN   = 2'd1,
    MC_CMD_HOLD  = 2'd2
  } mc_cmd_e;

  function automatic mc_cmd_e mc_decode(input logic [7:0] code);
    case (code)
      MC_STATE_RESET: return MC_CMD_RESET;
      MC_STATE_RUN:   return MC_CMD_RUN;
      default:        return MC_CMD_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/multi_counter_if.sv
// Command/status bundle for LANES counter channels, packed per lane.
// master = register-file side, slave = counter side.
interface multi_counter_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
);
  logic [LANES*WIDTH-1:0] interval;
  logic [LANES*8-1:0]     state;
  logic [LANES-1:0]       oneshot;
  logic [LANES*WIDTH-1:0] counter;
  logic [LANES-1:0]       tick;
  logic [LANES-1:0]       wrap;
  logic [LANES-1:0]       done;

  modport master (
    output interval, state, oneshot,
    input  counter, tick, wrap, done
  );

  modport slave (
    input  interval, state, oneshot,
    output counter, tick, wrap, done
  );
endinterface

// File: rtl/mc_channel.sv
// One interval-counter channel: divider, event counter, tick/wrap pulses
// and one-shot latch, driven by a single-lane multi_counter_if.
module mc_channel
  import mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  multi_counter_if.slave ch
);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] limit;

  // interval 0 behaves as 1, so the terminal divider value is never below 0
  assign limit = (ch.interval == '0) ? '0 : ch.interval - 1'b1;

  always_comb begin
    div_d     = div_q;
    counter_d = counter_q;
    done_d    = done_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    case (mc_decode(ch.state))
      MC_CMD_RESET: begin
        div_d     = '0;
        counter_d = '0;
        done_d    = 1'b0;
      end
      MC_CMD_RUN: begin
        if (!done_q) begin
          if (div_q >= limit) begin
            div_d     = '0;
            counter_d = counter_q + 1'b1;
            tick_d    = 1'b1;
            wrap_d    = &counter_q;
            done_d    = ch.oneshot;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      counter_q <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      counter_q <= counter_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign ch.counter = counter_q;
  assign ch.tick    = tick_q;
  assign ch.wrap    = wrap_q;
  assign ch.done    = done_q;

endmodule

// File: rtl/multi_counter.sv
// CHANNELS independent interval counters sliced from packed vectors.
// Define MC_IRQ_EN to add sticky per-channel pending bits, irq and irq_clr.
module multi_counter
  import mc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] interval,
  input  logic [CHANNELS*8-1:0]     state,
  input  logic [CHANNELS-1:0]       oneshot,
  output logic [CHANNELS*WIDTH-1:0] counter,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       wrap,
  output logic [CHANNELS-1:0]       done
`ifdef MC_IRQ_EN
  ,
  input  logic [CHANNELS-1:0]       irq_clr,
  output logic                      irq
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      multi_counter_if #(.WIDTH(WIDTH), .LANES(1)) ch_bus ();

      assign ch_bus.interval = interval[gi*WIDTH +: WIDTH];
      assign ch_bus.state    = state[gi*8 +: 8];
      assign ch_bus.oneshot  = oneshot[gi];

      mc_channel #(.WIDTH(WIDTH)) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .ch    (ch_bus)
      );

      assign counter[gi*WIDTH +: WIDTH] = ch_bus.counter;
      assign tick[gi]                   = ch_bus.tick[0];
      assign wrap[gi]                   = ch_bus.wrap[0];
      assign done[gi]                   = ch_bus.done[0];
    end
  endgenerate

`ifdef MC_IRQ_EN
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic                irq_q;

  // a tick in the same cycle as its clear keeps the bit pending
  assign pend_d = (pend_q & ~irq_clr) | tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/multi_counter.md
# multi_counter

Parametrised multi-channel interval counter for the P0 peripheral set. Each of CHANNELS independent channels divides the clock by a programmable interval and increments a WIDTH-bit event counter. Channels are controlled by the same three-state command (reset/run/halt) as the single-channel counter, and add one-shot mode, tick/wrap pulses and an optional interrupt. The block sits behind the MMIO register file, which drives all inputs directly and samples all outputs directly.

## Interface
Parameters:
- WIDTH, 32, width of the interval, divider and event counter per channel (≥2)
- CHANNELS, 4, number of independent channels (1..16)

Ports (channel i occupies slice [i*W +: W] of each packed vector):
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- interval  input  CHANNELS*WIDTH  per-channel clock divide ratio
- state  input  CHANNELS*8  per-channel command: 0 RESET, 1 RUN, 2 HALT, other values treated as HALT
- oneshot  input  CHANNELS  1 = stop after the first increment, 0 = periodic
- counter  output  CHANNELS*WIDTH  per-channel event count (registered)
- tick  output  CHANNELS  one-cycle pulse, cycle after counter increments
- wrap  output  CHANNELS  one-cycle pulse, cycle after counter wraps all-ones → 0
- done  output  CHANNELS  level, one-shot channel has fired
- irq  output  1  only with MC_IRQ_EN, see Configuration
- irq_clr  input  CHANNELS  only with MC_IRQ_EN, write-one-to-clear

## Operation
- Per-channel registers: div[WIDTH], counter[WIDTH], tick, wrap, done (all reset to 0 by rst_n).
- Effective interval N = max(interval, 1).
- RESET: div, counter, tick, wrap, done ← 0 on the next edge.
- RUN, done = 0: if div ≥ N−1, div ← 0, counter ← counter+1 (mod 2^WIDTH), tick ← 1; else div ← div+1, tick ← 0.
- wrap ← 1 exactly when the increment takes counter from all-ones to 0; otherwise 0.
- One-shot: on the edge that increments with oneshot=1, done ← 1. While done=1, div and counter hold and tick/wrap are 0, regardless of RUN. Only RESET clears done.
- HALT or illegal code: div, counter and done hold; tick and wrap ← 0.
- Comparison uses ≥, so lowering interval mid-run below the current div forces an increment on the next RUN cycle. It never overshoots.
- oneshot is sampled only on the increment edge. Changing it mid-run takes effect at the next increment.
- Channels share nothing except clk/rst_n (and the irq OR).

## Timing
- With N and RUN asserted continuously from a fresh RESET, the first increment lands on the Nth RUN edge and then every N edges.
- N=1 increments every RUN cycle.
- counter, tick and wrap change on the same edge; tick is high for exactly one cycle per increment.
- State change latency: the command sampled at edge k acts at edge k. There is no pipeline.
- rst_n assertion mid-run clears all outputs immediately (asynchronous). Deassertion is assumed synchronised upstream.

## Configuration
- MC_IRQ_EN defined: adds a per-channel sticky pending bit, set on tick and cleared by irq_clr[i]. Set wins over a clear in the same cycle. irq = OR of pending bits, registered, reset 0. Adds ports irq and irq_clr.
- MC_IRQ_EN undefined: no pending logic and no irq/irq_clr ports. All other behaviour is identical.

## Structure
- Package mc_pkg: state codes MC_STATE_RESET=8'd0, MC_STATE_RUN=8'd1, MC_STATE_HALT=8'd2, shared with the register-file decoder.
- Sub-module mc_channel (WIDTH parameter) implements one channel. The top-level instantiates it CHANNELS times in a generate loop and slices the packed vectors.
- The top level holds only slicing and the optional irq logic.

## Test plan
- Fresh reset, ch0 interval=3 RUN for 10 cycles → counter=3, tick high on cycles 3, 6, 9 only.
- interval=0 and interval=1, RUN 5 cycles → counter=5 in both, tick high every cycle.
- WIDTH=4 instance, interval=1, preload by running 15 cycles, then 1 more → counter 15→0, wrap pulses once, tick pulses.
- oneshot=1, interval=4, RUN 20 cycles → counter=1, done=1 from cycle 4. HALT then RUN → unchanged. RESET → counter=0, done=0.
- interval=10, RUN 7 cycles, change interval to 3 → increment on next edge, then every 3. HALT 5 cycles in between → counter and div frozen, tick 0. rst_n low mid-run → all outputs 0 asynchronously.
- MC_IRQ_EN: ch1 and ch2 tick → irq=1. Clear ch1 → irq stays 1. Clear ch2 → irq=0 next cycle. Clear coinciding with a tick → pending stays set.
